instr_fetch_unit: RTL and testbench

- Parametrised fetch front end for the byte-wide instruction ROM.
- Issues consecutive byte addresses from the current PC and assembles INSTR_BYTES ROM bytes into one instruction word.
- Hands the word to the instruction receiver over a valid/ready handshake, then advances the PC.
- Generalises the fixed single-byte go/finish fetch path: configurable instruction length, ROM latency and byte order; PC redirect with abort; stall support.

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch front end for a byte-wide instruction ROM. It issues INSTR_BYTES consecutive
// addresses from the PC, assembles the returned bytes and hands the word over valid/ready.
module instr_fetch_unit #(
  parameter int              PC_W        = 32,
  parameter int              ADDR_W      = 10,
  parameter int              INSTR_BYTES = 4,
  parameter int              ROM_LAT     = 1,
  parameter int              BIG_ENDIAN  = 0,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_wren,
  input  logic [PC_W-1:0]          init_pc,
  input  logic                     pc_wr_en,
  input  logic [PC_W-1:0]          pc_wr_data,
  input  logic                     go,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [7:0]               rom_data,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic [PC_W-1:0]          instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     finish,
  output logic                     busy,
  output logic [PC_W-1:0]          pc_out
);

  localparam int CW = $clog2(INSTR_BYTES + 1);
  localparam int LW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [CW-1:0] C_N    = CW'(INSTR_BYTES);
  localparam logic [LW-1:0] C_LAST = LW'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PC_W-1:0]          r_pc;
  logic [PC_W-1:0]          r_instr_pc;
  logic [CW-1:0]            r_iss_cnt;
  logic [LW-1:0]            r_cap_cnt;
  logic [ROM_LAT-1:0]       r_vld_sr;
  logic [8*INSTR_BYTES-1:0] r_instr;
  logic                     r_instr_valid;
  logic                     r_finish;

  logic                     w_abort;
  logic [PC_W-1:0]          w_abort_pc;
  logic                     w_accept;
  logic                     w_issue;
  logic                     w_cap;
  logic                     w_last_cap;
  logic [LW-1:0]            w_lane;
  logic [ADDR_W-1:0]        w_addr_ofs;

  assign w_abort    = init_wren | pc_wr_en;
  assign w_abort_pc = init_wren ? init_pc : pc_wr_data;
  assign w_accept   = r_instr_valid & instr_ready;
  assign w_issue    = (r_state == S_FETCH) && (r_iss_cnt != C_N);
  assign w_cap      = r_vld_sr[ROM_LAT-1];
  assign w_last_cap = w_cap && (r_cap_cnt == C_LAST);
  assign w_lane     = (BIG_ENDIAN != 0) ? (C_LAST - r_cap_cnt) : r_cap_cnt;

  // Once every byte is issued the offset sticks at the last one so rom_addr holds.
  assign w_addr_ofs = (r_iss_cnt == C_N) ? ADDR_W'(INSTR_BYTES - 1) : ADDR_W'(r_iss_cnt);
  assign rom_addr   = r_pc[ADDR_W-1:0] + w_addr_ofs;

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign finish      = r_finish;
  assign busy        = (r_state != S_IDLE);
  assign pc_out      = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (go)         w_state_nxt = S_FETCH;
        S_FETCH: if (w_last_cap) w_state_nxt = S_DONE;
        S_DONE:  if (w_accept)   w_state_nxt = S_IDLE;
        default:                 w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Clearing the valid tracker on abort guarantees late ROM returns are never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr_pc    <= '0;
      r_iss_cnt     <= '0;
      r_cap_cnt     <= '0;
      r_vld_sr      <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_finish      <= 1'b0;
    end else if (w_abort) begin
      r_pc          <= w_abort_pc;
      r_iss_cnt     <= '0;
      r_cap_cnt     <= '0;
      r_vld_sr      <= '0;
      r_instr_valid <= 1'b0;
      r_finish      <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (r_state == S_FETCH) begin
        r_vld_sr <= (r_vld_sr << 1) | ROM_LAT'(w_issue);
        if (w_issue) r_iss_cnt <= r_iss_cnt + 1'b1;
        if (w_cap) begin
          r_instr[8*w_lane +: 8] <= rom_data;
          r_cap_cnt              <= w_last_cap ? '0 : r_cap_cnt + 1'b1;
        end
        if (w_last_cap) begin
          r_instr_valid <= 1'b1;
          r_instr_pc    <= r_pc;
        end
      end
      if (w_accept) begin
        r_instr_valid <= 1'b0;
        r_finish      <= 1'b1;
        r_pc          <= r_pc + PC_W'(INSTR_BYTES);
        r_iss_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a default instance and a 2-byte/latency-3/big-endian
// instance, each fed by a behavioural ROM and checked against a byte-assembly model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        init_wren0, pc_wr_en0, go0, instr_ready0;
  logic [31:0] init_pc0, pc_wr_data0;
  logic [9:0]  rom_addr0;
  logic [7:0]  rom_data0;
  logic [31:0] instr0, instr_pc0, pc_out0;
  logic        instr_valid0, finish0, busy0;

  logic        init_wren1, pc_wr_en1, go1, instr_ready1;
  logic [31:0] init_pc1, pc_wr_data1;
  logic [9:0]  rom_addr1;
  logic [7:0]  rom_data1;
  logic [15:0] instr1;
  logic [31:0] instr_pc1, pc_out1;
  logic        instr_valid1, finish1, busy1;

  instr_fetch_unit u0 (
    .clk(clk), .rst_n(rst_n), .init_wren(init_wren0), .init_pc(init_pc0),
    .pc_wr_en(pc_wr_en0), .pc_wr_data(pc_wr_data0), .go(go0), .rom_addr(rom_addr0),
    .rom_data(rom_data0), .instr(instr0), .instr_pc(instr_pc0), .instr_valid(instr_valid0),
    .instr_ready(instr_ready0), .finish(finish0), .busy(busy0), .pc_out(pc_out0)
  );

  instr_fetch_unit #(.INSTR_BYTES(2), .ROM_LAT(3), .BIG_ENDIAN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_wren(init_wren1), .init_pc(init_pc1),
    .pc_wr_en(pc_wr_en1), .pc_wr_data(pc_wr_data1), .go(go1), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .instr_ready(instr_ready1), .finish(finish1), .busy(busy1), .pc_out(pc_out1)
  );

  // Behavioural ROMs: data appears ROM_LAT cycles after the address is presented.
  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  logic [9:0] a0_q;
  logic [9:0] a1_q [3];
  always @(posedge clk) begin
    a0_q    <= rom_addr0;
    a1_q[0] <= rom_addr1;
    a1_q[1] <= a1_q[0];
    a1_q[2] <= a1_q[1];
  end
  assign rom_data0 = mem0[a0_q];
  assign rom_data1 = mem1[a1_q[2]];

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] pc0m, pc1m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word0(input logic [31:0] pc);
    logic [31:0] w;
    logic [9:0]  a;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      a = pc[9:0] + 10'(k);
      w[8*k +: 8] = mem0[a];
    end
    return w;
  endfunction

  function automatic logic [15:0] word1(input logic [31:0] pc);
    logic [9:0] a;
    a = pc[9:0];
    return {mem1[a], mem1[a + 10'd1]};
  endfunction

  task automatic init0(input logic [31:0] v);
    init_wren0 = 1'b1;
    init_pc0   = v;
    step();
    init_wren0 = 1'b0;
    pc0m = v;
    chk("init0_pc", pc_out0, pc0m);
    chk("init0_valid", instr_valid0, 0);
  endtask

  task automatic init1(input logic [31:0] v);
    init_wren1 = 1'b1;
    init_pc1   = v;
    step();
    init_wren1 = 1'b0;
    pc1m = v;
    chk("init1_pc", pc_out1, pc1m);
  endtask

  task automatic wait_valid0();
    int lat;
    logic [9:0] ea;
    go0 = 1'b1;
    step();
    go0 = 1'b0;
    lat = 0;
    while (!instr_valid0 && lat < 20) begin
      if (lat < 4) begin
        ea = pc0m[9:0] + 10'(lat);
        chk("rom_addr0", rom_addr0, ea);
      end
      step();
      lat++;
    end
    ea = pc0m[9:0] + 10'd3;
    chk("latency0", lat, 5);
    chk("instr0", instr0, word0(pc0m));
    chk("instr_pc0", instr_pc0, pc0m);
    chk("busy0_done", busy0, 1);
    chk("addr_hold0", rom_addr0, ea);
  endtask

  task automatic stall0(input int n);
    logic [31:0] w;
    w = word0(pc0m);
    for (int i = 0; i < n; i++) begin
      go0 = 1'($urandom_range(0, 1));
      step();
      chk("stall0_valid", instr_valid0, 1);
      chk("stall0_instr", instr0, w);
      chk("stall0_ipc", instr_pc0, pc0m);
      chk("stall0_finish", finish0, 0);
    end
    go0 = 1'b0;
  endtask

  task automatic accept0();
    instr_ready0 = 1'b1;
    step();
    instr_ready0 = 1'b0;
    pc0m = pc0m + 32'd4;
    chk("acc0_finish", finish0, 1);
    chk("acc0_valid", instr_valid0, 0);
    chk("acc0_pc", pc_out0, pc0m);
    chk("acc0_busy", busy0, 0);
    step();
    chk("acc0_finish_drop", finish0, 0);
    chk("idle0_addr", rom_addr0, pc0m[9:0]);
  endtask

  task automatic fetch1();
    int lat;
    go1 = 1'b1;
    step();
    go1 = 1'b0;
    lat = 0;
    while (!instr_valid1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency1", lat, 5);
    chk("instr1", instr1, word1(pc1m));
    chk("instr_pc1", instr_pc1, pc1m);
    instr_ready1 = 1'b1;
    step();
    instr_ready1 = 1'b0;
    pc1m = pc1m + 32'd2;
    chk("acc1_finish", finish1, 1);
    chk("acc1_pc", pc_out1, pc1m);
    step();
    chk("acc1_finish_drop", finish1, 0);
  endtask

  // Redirect or init r cycles after go; whatever was in flight or held is dropped.
  task automatic abort0(input int r, input logic use_init, input logic use_wr,
                        input logic [31:0] ipc, input logic [31:0] wpc);
    go0 = 1'b1;
    step();
    go0 = 1'b0;
    for (int i = 1; i < r; i++) step();
    init_wren0  = use_init;
    init_pc0    = ipc;
    pc_wr_en0   = use_wr;
    pc_wr_data0 = wpc;
    go0         = 1'($urandom_range(0, 1));
    step();
    init_wren0 = 1'b0;
    pc_wr_en0  = 1'b0;
    go0        = 1'b0;
    pc0m = use_init ? ipc : wpc;
    chk("abort0_valid", instr_valid0, 0);
    chk("abort0_busy", busy0, 0);
    chk("abort0_finish", finish0, 0);
    chk("abort0_pc", pc_out0, pc0m);
  endtask

  initial begin
    rst_n = 1'b0;
    init_wren0 = 0; pc_wr_en0 = 0; go0 = 0; instr_ready0 = 0; init_pc0 = 0; pc_wr_data0 = 0;
    init_wren1 = 0; pc_wr_en1 = 0; go1 = 0; instr_ready1 = 0; init_pc1 = 0; pc_wr_data1 = 0;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
    mem1[8] = 8'hAB; mem1[9] = 8'hCD;
    pc0m = 0;
    pc1m = 0;

    step();
    step();
    chk("rst_valid", instr_valid0, 0);
    chk("rst_finish", finish0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_instr", instr0, 0);
    chk("rst_ipc", instr_pc0, 0);
    chk("rst_pc", pc_out0, 0);
    chk("rst_addr", rom_addr0, 0);
    rst_n = 1'b1;
    step();

    wait_valid0();
    chk("basic_instr", instr0, 32'h44332211);
    accept0();
    chk("basic_pc", pc_out0, 32'd4);

    wait_valid0();
    stall0(6);
    accept0();

    init1(32'd8);
    fetch1();
    chk("be_pc", pc_out1, 32'd10);
    init1(32'd1023);
    fetch1();
    for (int i = 0; i < 4; i++) begin
      init1($urandom);
      fetch1();
    end

    init0(32'd1022);
    wait_valid0();
    chk("wrap_ipc", instr_pc0, 32'd1022);
    accept0();
    chk("wrap_pc", pc_out0, 32'd1026);

    init0(32'd32);
    abort0(2, 1'b0, 1'b1, 32'd0, 32'd40);
    chk("abort_pc40", pc_out0, 32'd40);
    wait_valid0();
    accept0();

    wait_valid0();
    init_wren0 = 1'b1; init_pc0 = 32'd100;
    pc_wr_en0 = 1'b1; pc_wr_data0 = 32'd200;
    instr_ready0 = 1'b1;
    step();
    init_wren0 = 1'b0; pc_wr_en0 = 1'b0; instr_ready0 = 1'b0;
    pc0m = 32'd100;
    chk("prio_pc", pc_out0, 32'd100);
    chk("prio_finish", finish0, 0);
    chk("prio_valid", instr_valid0, 0);
    step();
    chk("prio_finish_late", finish0, 0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic ui;
        logic uw;
        ui = 1'($urandom_range(0, 1));
        uw = ui ? 1'($urandom_range(0, 1)) : 1'b1;
        abort0($urandom_range(1, 7), ui, uw, $urandom, $urandom);
      end else begin
        wait_valid0();
        stall0($urandom_range(0, 3));
        accept0();
      end
    end

    init0(32'd50);
    go0 = 1'b1;
    step();
    go0 = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_finish", finish0, 0);
    chk("arst_pc", pc_out0, 0);
    chk("arst_addr", rom_addr0, 0);
    chk("arst_instr", instr0, 0);
    chk("arst_ipc", instr_pc0, 0);
    step();
    rst_n = 1'b1;
    pc0m = 0;
    step();
    wait_valid0();
    accept0();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
